// File: rtl/ula_seq_ctrl_if.sv
// Signal bundle between the ALU sequencer and its surroundings: request inputs,
// selector result return, and the select/operand/status outputs.
interface ula_seq_ctrl_if #(
  parameter int W = 4
);
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         use_acc;
  logic         clr;
  logic [W-1:0] f;
  logic         s2;
  logic         s1;
  logic         s0;
  logic [W-1:0] opa;
  logic [W-1:0] opb;
  logic         busy;
  logic         done;
  logic [W-1:0] acc;
  logic         zero;
  logic         neg;

  // The requester/ALU side drives requests and the selected result back in.
  modport master (
    output start, op, a, b, use_acc, clr, f,
    input  s2, s1, s0, opa, opb, busy, done, acc, zero, neg
  );

  modport slave (
    input  start, op, a, b, use_acc, clr, f,
    output s2, s1, s0, opa, opb, busy, done, acc, zero, neg
  );
endinterface

// File: rtl/ula_seq_ctrl.sv
// Sequencer around the 8-way ALU result selector: launches one operation per
// start, waits SETTLE cycles, then captures f into the accumulator and flags.
module ula_seq_ctrl #(
  parameter int W      = 4,
  parameter int SETTLE = 1
) (
  input  logic          clk,
  input  logic          rst,
  ula_seq_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] CNT_INIT = 3'(SETTLE - 1);

  state_t       state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [2:0]   sel_q, sel_d;
  logic [W-1:0] opa_q, opa_d;
  logic [W-1:0] opb_q, opb_d;
  logic [W-1:0] acc_q, acc_d;
  logic         zero_q, zero_d;
  logic         neg_q, neg_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.clr) begin
          acc_d  = '0;
          zero_d = 1'b0;
          neg_d  = 1'b0;
        end
        // Operand A feedback uses acc_q, i.e. the value before a same-edge clear.
        if (bus.start) begin
          sel_d   = bus.op;
          opa_d   = bus.use_acc ? acc_q : bus.a;
          opb_d   = bus.b;
          cnt_d   = CNT_INIT;
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        if (cnt_q == 3'd0) begin
          acc_d   = bus.f;
          zero_d  = (bus.f == '0);
          neg_d   = bus.f[W-1];
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.s2   = sel_q[2];
  assign bus.s1   = sel_q[1];
  assign bus.s0   = sel_q[0];
  assign bus.opa  = opa_q;
  assign bus.opb  = opb_q;
  assign bus.acc  = acc_q;
  assign bus.zero = zero_q;
  assign bus.neg  = neg_q;
  assign bus.busy = (state_q == EXEC);
  assign bus.done = (state_q == DONE);
endmodule
